// File: rtl/fm_demod_mc_if.sv
// fm_demod_mc_if: FIFO-side handshake and data bundle
// for the multi-channel FM discriminator.
interface fm_demod_mc_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic                     in_empty;
  logic                     in_rd_en;
  logic signed [DATA_W-1:0] real_in;
  logic signed [DATA_W-1:0] imag_in;
  logic                     out_full;
  logic                     out_wr_en;
  logic signed [DATA_W-1:0] demod_out;
  logic [CH_W-1:0]          out_ch;
  logic                     busy;

  modport master (
    output in_empty, real_in, imag_in, out_full,
    input  in_rd_en, out_wr_en, demod_out, out_ch, busy
  );

  modport slave (
    input  in_empty, real_in, imag_in, out_full,
    output in_rd_en, out_wr_en, demod_out, out_ch, busy
  );
endinterface

// File: rtl/fm_demod_mc.sv
// fm_demod_mc: multi-channel FM discriminator, conj-multiply phase
// difference plus quantised qarctan with a serial restoring divider.
module fm_demod_mc #(
  parameter int          DATA_W     = 32,
  parameter int          QUANT_BITS = 10,
  parameter logic [31:0] GAIN       = 32'h2F6,
  parameter int          NUM_CH     = 1,
  parameter logic [31:0] PRIME_VAL  = 32'h4A6
) (
  input logic          clk,
  input logic          reset,
  fm_demod_mc_if.slave bus
);
  localparam int  CH_W   = $clog2(NUM_CH) + 1;
  localparam int  NSLOT  = 2 ** CH_W;
  localparam int  PW     = 2 * DATA_W;
  localparam int  CNT_W  = $clog2(DATA_W) + 1;
  localparam real PI     = 3.141592653589793;
  localparam int  QPI_I  = $rtoi(PI / 4.0 * (2.0 ** QUANT_BITS) + 0.5);
  localparam int  QPI3_I = $rtoi(3.0 * PI / 4.0 * (2.0 ** QUANT_BITS) + 0.5);

  localparam logic signed [DATA_W-1:0] QPI    = DATA_W'(QPI_I);
  localparam logic signed [DATA_W-1:0] QPI3   = DATA_W'(QPI3_I);
  localparam logic signed [DATA_W-1:0] GAIN_S = DATA_W'(GAIN);
  localparam logic signed [DATA_W-1:0] ONE    = DATA_W'(1);
  localparam logic [CNT_W-1:0]         LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]          CH_END = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, MIX, DIV, SCALE, OUTPUT} state_t;

  function automatic logic signed [DATA_W-1:0] deq(
    input logic signed [PW-1:0] v
  );
    return DATA_W'(v >>> QUANT_BITS);
  endfunction

  function automatic logic signed [PW-1:0] sx(
    input logic signed [DATA_W-1:0] v
  );
    return PW'(v);
  endfunction

  state_t state, nxt;
  logic   rd, wr;

  logic [CH_W-1:0]          ch_ptr, ch_q;
  logic [NSLOT-1:0]         primed;
  logic signed [DATA_W-1:0] prev_re [NSLOT];
  logic signed [DATA_W-1:0] prev_im [NSLOT];
  logic signed [DATA_W-1:0] rp, ip, rc, ic;
  logic signed [DATA_W-1:0] x, y, ay, num, den, base, base_r;
  logic signed [DATA_W-1:0] r, ang, scaled, demod_q;
  logic [DATA_W-1:0]        num_mag, den_mag, quo, dvs, rem;
  logic [DATA_W:0]          rem_sh;
  logic [DATA_W+1:0]        diff;
  logic                     ge, neg_q, y_neg;
  logic [CNT_W-1:0]         cnt;

  // mix products, qarctan operands, divider step and final scaling
  always_comb begin
    x    = deq(sx(rp) * sx(rc)) - deq(-(sx(ip) * sx(ic)));
    y    = deq(sx(rp) * sx(ic)) + deq(-(sx(ip) * sx(rc)));
    ay   = (y[DATA_W-1] ? -y : y) + ONE;
    num  = (x - ay) <<< QUANT_BITS;
    den  = x + ay;
    base = QPI;
    if (x[DATA_W-1]) begin
      num  = (x + ay) <<< QUANT_BITS;
      den  = ay - x;
      base = QPI3;
    end
    num_mag = num[DATA_W-1] ? DATA_W'(-num) : num;
    den_mag = den[DATA_W-1] ? DATA_W'(-den) : den;
    rem_sh  = {rem, quo[DATA_W-1]};
    diff    = {1'b0, rem_sh} - {2'b00, dvs};
    ge      = ~|diff[DATA_W+1:DATA_W];
    r       = neg_q ? -$signed(quo) : $signed(quo);
    ang     = base_r - deq(sx(QPI) * sx(r));
    if (y_neg) ang = -ang;
    scaled  = deq(sx(ang) * sx(GAIN_S));
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next state and FIFO strobes
  always_comb begin
    nxt = state;
    rd  = 1'b0;
    wr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.in_empty) begin
          rd  = 1'b1;
          nxt = primed[ch_ptr] ? MIX : OUTPUT;
        end
      end
      MIX:   nxt = DIV;
      DIV:   if (cnt == LAST) nxt = SCALE;
      SCALE: nxt = OUTPUT;
      OUTPUT: begin
        if (!bus.out_full) begin
          wr  = 1'b1;
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // channel history, divider registers and result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_ptr  <= '0;
      ch_q    <= '0;
      primed  <= '0;
      rp      <= '0;
      ip      <= '0;
      rc      <= '0;
      ic      <= '0;
      quo     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      y_neg   <= 1'b0;
      base_r  <= '0;
      demod_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        prev_re[i] <= '0;
        prev_im[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (rd) begin
            rp              <= prev_re[ch_ptr];
            ip              <= prev_im[ch_ptr];
            rc              <= bus.real_in;
            ic              <= bus.imag_in;
            prev_re[ch_ptr] <= bus.real_in;
            prev_im[ch_ptr] <= bus.imag_in;
            ch_q            <= ch_ptr;
            ch_ptr <= (ch_ptr == CH_END) ? '0 : ch_ptr + 1'b1;
            if (!primed[ch_ptr]) begin
              primed[ch_ptr] <= 1'b1;
              demod_q        <= DATA_W'(PRIME_VAL);
            end
          end
        end
        MIX: begin
          quo    <= num_mag;
          dvs    <= den_mag;
          rem    <= '0;
          cnt    <= '0;
          neg_q  <= num[DATA_W-1] ^ den[DATA_W-1];
          y_neg  <= y[DATA_W-1];
          base_r <= base;
        end
        DIV: begin
          quo <= {quo[DATA_W-2:0], ge};
          rem <= ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          cnt <= cnt + 1'b1;
        end
        SCALE:   demod_q <= scaled;
        default: ;
      endcase
    end
  end

  assign bus.in_rd_en  = rd;
  assign bus.out_wr_en = wr;
  assign bus.demod_out = demod_q;
  assign bus.out_ch    = ch_q;
  assign bus.busy      = (state != IDLE);
endmodule
